// File: rtl/cell_stream_ctrl.sv
// cell_stream_ctrl
//
// Sequencer and access arbiter for one single-port cell position RAM.
// Each RAM word is {posz, posy, posx}; word 0 holds the particle count.
// On start the count is read from word 0, clamped to the RAM depth, and
// particles 1..count are streamed to the force pipeline over valid/ready.
// The RAM has a fixed two-cycle read latency, so reads are only issued
// while the reads in flight plus the buffered entries still fit in the
// four-entry output FIFO. Motion-update write-back is granted only while
// no stream is active.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             single-cycle pulse, begin streaming one cell
//   busy, done        stream active / single-cycle completion pulse
//   particle_cnt      clamped count latched from word 0
//   cnt_err           sticky, count exceeded PARTICLE_NUM-1
//   mem_*             single-port RAM interface (read data on mem_q)
//   out_*             particle stream (first-word-fall-through FIFO head)
//   wb_req/addr/data  write-back request, held until granted
//   wb_grant          combinational, write performed this cycle

module cell_stream_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_cnt,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_grant
);

    localparam logic [ADDR_WIDTH-1:0] MAX_INDEX  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [2:0]            FIFO_SLOTS = 3'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;

    logic [1:0]            rd_valid_pipe;
    logic [ADDR_WIDTH-1:0] rd_tag_pipe0, rd_tag_pipe1;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
    logic [1:0]            fifo_wr_ptr, fifo_rd_ptr;
    logic [2:0]            fifo_count;

    logic [1:0]            in_flight;
    logic                  credit_ok;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic [ADDR_WIDTH-1:0] raw_cnt;
    logic [ADDR_WIDTH-1:0] clamped_cnt;
    logic                  cnt_over;
    logic                  cnt_capture;
    logic                  start_accept;

    // Reads in flight are exactly the set bits of the valid pipe, so the
    // credit check needs no separate counter that could drift from it.
    assign in_flight  = {1'b0, rd_valid_pipe[0]} + {1'b0, rd_valid_pipe[1]};
    assign credit_ok  = ({1'b0, in_flight} + fifo_count) < FIFO_SLOTS;

    assign fifo_empty = (fifo_count == 3'd0);
    assign fifo_pop   = !fifo_empty && out_ready;

    // Only particle reads land in the FIFO; the word-0 count read returns
    // while still in WAIT_CNT and is consumed there instead.
    assign fifo_push  = rd_valid_pipe[1] && ((state == STREAM) || (state == DRAIN));

    assign raw_cnt     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_over    = (raw_cnt > MAX_INDEX);
    assign clamped_cnt = cnt_over ? MAX_INDEX : raw_cnt;

    // The head is forced to zero when empty so stale storage never shows.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_data[fifo_rd_ptr];
    assign out_last  = !fifo_empty && (fifo_tag[fifo_rd_ptr] == particle_cnt);

    // State register, read pointer and the read-return valid/tag pipe.
    // Clearing the valid pipe on reset discards data from aborted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            rd_valid_pipe <= 2'b00;
            rd_tag_pipe0  <= '0;
            rd_tag_pipe1  <= '0;
        end else begin
            state         <= state_next;
            rd_ptr        <= rd_ptr_next;
            rd_valid_pipe <= {rd_valid_pipe[0], mem_rden};
            rd_tag_pipe0  <= mem_address;
            rd_tag_pipe1  <= rd_tag_pipe0;
        end
    end

    // Next-state, RAM port arbitration and status outputs. Start wins over
    // a pending write-back in IDLE; DRAIN looks ahead at the pop so done
    // fires the cycle after the last particle leaves the FIFO.
    always_comb begin
        state_next   = state;
        rd_ptr_next  = rd_ptr;
        mem_address  = '0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_data     = '0;
        wb_grant     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        start_accept = 1'b0;
        cnt_capture  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = RD_CNT;
                end else if (wb_req && !rst) begin
                    wb_grant    = 1'b1;
                    mem_wren    = 1'b1;
                    mem_address = wb_addr;
                    mem_data    = wb_data;
                end
            end
            RD_CNT: begin
                busy       = 1'b1;
                mem_rden   = 1'b1;
                state_next = WAIT_CNT;
            end
            WAIT_CNT: begin
                busy = 1'b1;
                if (rd_valid_pipe[1]) begin
                    cnt_capture = 1'b1;
                    rd_ptr_next = ADDR_WIDTH'(1);
                    state_next  = (clamped_cnt == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (credit_ok) begin
                    mem_rden    = 1'b1;
                    mem_address = rd_ptr;
                    rd_ptr_next = rd_ptr + ADDR_WIDTH'(1);
                    if (rd_ptr == particle_cnt) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((rd_valid_pipe == 2'b00) &&
                    (fifo_empty || ((fifo_count == 3'd1) && fifo_pop))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latched count and sticky error flag. The error is cleared by the
    // next accepted start and set again only if that count is also clamped.
    always_ff @(posedge clk) begin
        if (rst) begin
            particle_cnt <= '0;
            cnt_err      <= 1'b0;
        end else if (start_accept) begin
            cnt_err <= 1'b0;
        end else if (cnt_capture) begin
            particle_cnt <= clamped_cnt;
            if (cnt_over) begin
                cnt_err <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy. The credit rule makes overflow
    // impossible; the assertion catches any break in that reasoning.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= 2'd0;
            fifo_rd_ptr <= 2'd0;
            fifo_count  <= 3'd0;
        end else begin
            assert (!(fifo_push && !fifo_pop && (fifo_count == FIFO_SLOTS)));
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: each entry carries its RAM address so the head can be
    // recognised as the final particle of the cell.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[fifo_wr_ptr] <= mem_q;
            fifo_tag[fifo_wr_ptr]  <= rd_tag_pipe1;
        end
    end

endmodule

// File: tb/tb_cell_stream_ctrl.sv
// tb_cell_stream_ctrl
//
// Directed bench for cell_stream_ctrl. A behavioural two-cycle-latency RAM
// sits on the memory port; word 0 is driven from word0_val and every other
// word holds a known pattern unless overwritten through the write port.
// Stimulus is applied and outputs are sampled on the falling clock edge.

module tb_cell_stream_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_cnt;
    logic          cnt_err;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_grant;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] word0_val;

    logic [DW-1:0] ram_wr_val  [256];
    bit            ram_wr_flag [256];
    logic [DW-1:0] ram_stage;

    always #5 clk = ~clk;

    cell_stream_ctrl #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .particle_cnt (particle_cnt),
        .cnt_err      (cnt_err),
        .mem_address  (mem_address),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_data     (mem_data),
        .mem_q        (mem_q),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .wb_req       (wb_req),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_grant     (wb_grant)
    );

    function automatic logic [DW-1:0] base_word(input int i);
        return {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
    endfunction

    // RAM model: address sampled on the rden edge, data appears on mem_q
    // one further edge later, i.e. valid two cycles after mem_rden.
    always @(posedge clk) begin
        if (mem_wren) begin
            ram_wr_val[mem_address]  <= mem_data;
            ram_wr_flag[mem_address] <= 1'b1;
        end
        if (mem_rden) begin
            if (mem_address == '0)
                ram_stage <= word0_val;
            else if (ram_wr_flag[mem_address])
                ram_stage <= ram_wr_val[mem_address];
            else
                ram_stage <= base_word(int'(mem_address));
        end
        mem_q <= ram_stage;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic req,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        start   = s;
        wb_req  = req;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_busy"},     DW'(busy),         DW'(0));
        checkOutput({tag, "_done"},     DW'(done),         DW'(0));
        checkOutput({tag, "_valid"},    DW'(out_valid),    DW'(0));
        checkOutput({tag, "_data"},     out_data,          DW'(0));
        checkOutput({tag, "_last"},     DW'(out_last),     DW'(0));
        checkOutput({tag, "_rden"},     DW'(mem_rden),     DW'(0));
        checkOutput({tag, "_wren"},     DW'(mem_wren),     DW'(0));
        checkOutput({tag, "_addr"},     DW'(mem_address),  DW'(0));
        checkOutput({tag, "_grant"},    DW'(wb_grant),     DW'(0));
        checkOutput({tag, "_pcnt"},     DW'(particle_cnt), DW'(0));
        checkOutput({tag, "_cnt_err"},  DW'(cnt_err),      DW'(0));
    endtask

    // One full cell stream. Cycle 0 is the start cycle. ready_mode 0 holds
    // out_ready high, 1 gives one ready cycle in four. wb_mode 1 raises a
    // write-back request mid-stream, 2 raises it together with start.
    task automatic run_stream(input int n_exp, input int ready_mode, input int wb_mode,
                              input logic [AW-1:0] wb_a, input logic [DW-1:0] wb_d,
                              input int exp_err, input int exp_first);
        int            beats       = 0;
        int            first_v     = -1;
        int            last_b      = -1;
        int            outstanding = 0;
        int            max_out     = 0;
        bit            done_seen   = 1'b0;
        bit            stalled     = 1'b0;
        bit            grant_busy  = 1'b0;
        logic [DW-1:0] held        = '0;

        @(negedge clk);
        out_ready = 1'b1;
        if (wb_mode == 2)
            applyStimulus(1'b1, 1'b1, wb_a, wb_d);
        else
            applyStimulus(1'b1, 1'b0, '0, '0);
        #1;
        if (wb_mode == 2) begin
            checkOutput("start_prio_grant", DW'(wb_grant), DW'(0));
            checkOutput("start_prio_wren",  DW'(mem_wren), DW'(0));
        end

        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (wb_mode == 1 && cyc == 5)
                applyStimulus(1'b0, 1'b1, wb_a, wb_d);
            out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
            #1;
            if (cyc == 1) begin
                checkOutput("busy_in_rd_cnt", DW'(busy),    DW'(1));
                checkOutput("cnt_err_cleared", DW'(cnt_err), DW'(0));
            end
            if (wb_req && wb_grant)
                grant_busy = 1'b1;
            if (mem_rden && mem_address != '0)
                outstanding++;
            if (outstanding > max_out)
                max_out = outstanding;
            if (stalled) begin
                checkOutput("stall_valid", DW'(out_valid), DW'(1));
                checkOutput("stall_data",  out_data,       held);
            end
            if (done) begin
                done_seen = 1'b1;
                checkOutput("beats",        DW'(beats),        DW'(n_exp));
                checkOutput("done_busy",    DW'(busy),         DW'(0));
                checkOutput("particle_cnt", DW'(particle_cnt), DW'(n_exp));
                checkOutput("cnt_err",      DW'(cnt_err),      DW'(exp_err));
                checkOutput("max_outstanding_le4", DW'(max_out <= 4), DW'(1));
                if (n_exp == 0)
                    checkOutput("done_cycle_empty", DW'(cyc), DW'(4));
                else
                    checkOutput("done_after_last", DW'(cyc), DW'(last_b + 1));
                if (ready_mode == 0 && n_exp > 1)
                    checkOutput("throughput", DW'(last_b - first_v), DW'(n_exp - 1));
                if (exp_first > 0)
                    checkOutput("first_valid_cycle", DW'(first_v), DW'(exp_first));
                break;
            end
            if (out_valid && out_ready) begin
                beats++;
                if (beats == 1)
                    first_v = cyc;
                last_b = cyc;
                checkOutput($sformatf("data_%0d", beats), out_data, exp_mem[beats]);
                checkOutput($sformatf("last_%0d", beats), DW'(out_last), DW'(beats == n_exp));
                outstanding--;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
        checkOutput("done_seen", DW'(done_seen), DW'(1));

        @(negedge clk);
        #1;
        checkOutput("done_single_pulse", DW'(done), DW'(0));
        checkOutput("idle_busy",         DW'(busy), DW'(0));
        if (wb_mode != 0) begin
            checkOutput("wb_held_off",   DW'(grant_busy),  DW'(0));
            checkOutput("wb_grant_idle", DW'(wb_grant),    DW'(1));
            checkOutput("wb_wren",       DW'(mem_wren),    DW'(1));
            checkOutput("wb_address",    DW'(mem_address), DW'(wb_a));
            checkOutput("wb_data",       mem_data,         wb_d);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        bit stale;

        for (int i = 0; i < 256; i++)
            exp_mem[i] = base_word(i);

        applyStimulus(1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        word0_val = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        $display("[TB] count 5, ready held high");
        word0_val = DW'(5);
        run_stream(5, 0, 0, '0, '0, 0, 7);

        $display("[TB] empty cell");
        word0_val = DW'(0);
        run_stream(0, 0, 0, '0, '0, 0, 0);

        $display("[TB] count 250 clamps to 219");
        word0_val = DW'(250);
        run_stream(219, 0, 0, '0, '0, 1, 0);

        $display("[TB] count 10 with backpressure");
        word0_val = DW'(10);
        run_stream(10, 1, 0, '0, '0, 0, 0);

        $display("[TB] write-back during stream");
        run_stream(10, 0, 1, AW'(7), {24{4'hA}}, 0, 0);
        exp_mem[7] = {24{4'hA}};

        $display("[TB] start and write-back in the same cycle");
        run_stream(10, 0, 2, AW'(3), {24{4'h5}}, 0, 0);
        exp_mem[3] = {24{4'h5}};

        $display("[TB] reset mid-stream");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checkOutput("mid_busy", DW'(busy),     DW'(1));
        checkOutput("mid_rden", DW'(mem_rden), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("mid_reset");
        rst   = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid || busy)
                stale = 1'b1;
        end
        checkOutput("no_stale_valid", DW'(stale), DW'(0));

        $display("[TB] fresh stream after reset");
        run_stream(10, 0, 0, '0, '0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
